// File: rtl/adc_scan_hyst_pkg.sv
// rtl/adc_scan_hyst_pkg.sv - shared state type and default widths for the ADC scan sequencer
package adc_scan_pkg;

    typedef enum logic [1:0] {IDLE, REQ, ACK, PAUSE} scan_state_t;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_ADDR_W = 3;

endpackage

// File: rtl/adc_scan_hyst_if.sv
// rtl/adc_scan_hyst_if.sv - conversion request/result handshake between scan sequencer and capture engine
interface adc_scan_hyst_if
    import adc_scan_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int ADDR_W = ADC_ADDR_W
) ();

    logic              ctl_valid;
    logic [ADDR_W-1:0] address;
    logic              adc_ack;
    logic              adc_ready;
    logic [DATA_W-1:0] adc_data;

    modport master (
        output ctl_valid,
        output address,
        output adc_ack,
        input  adc_ready,
        input  adc_data
    );

    modport slave (
        input  ctl_valid,
        input  address,
        input  adc_ack,
        output adc_ready,
        output adc_data
    );

endinterface

// File: rtl/adc_scan_hyst_cell.sv
// rtl/adc_scan_hyst_cell.sv - per-channel sample store and hysteresis flag
// ADC_SCAN_AVG_EN inserts a 1/4-weight IIR filter ahead of storage and compare.
module adc_hyst_cell
    import adc_scan_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int HIGH   = 3000,
    parameter int LOW    = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] value,
    output logic              flag
);

    localparam logic [DATA_W-1:0] HIGH_V = DATA_W'(HIGH);
    localparam logic [DATA_W-1:0] LOW_V  = DATA_W'(LOW);

    logic [DATA_W-1:0] v_next;

`ifdef ADC_SCAN_AVG_EN
    logic                     loaded;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W:0]   step;

    // The filtered value always lies between old avg and sample, so DATA_W-bit wrap-around add is exact.
    assign diff   = $signed({1'b0, sample}) - $signed({1'b0, value});
    assign step   = diff >>> 2;
    assign v_next = loaded ? value + DATA_W'(step) : sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            loaded <= 1'b0;
        end else if (upd) begin
            loaded <= 1'b1;
        end
    end
`else
    assign v_next = sample;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            flag  <= 1'b0;
        end else if (upd) begin
            value <= v_next;
            if (v_next >= HIGH_V) begin
                flag <= 1'b1;
            end else if (v_next <= LOW_V) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_scan_hyst.sv
// rtl/adc_scan_hyst.sv - round-robin ADC channel scanner with per-channel hysteresis flags
// Optional ADC_SCAN_AVG_EN enables the per-channel IIR filter inside adc_hyst_cell.
module adc_scan_hyst
    import adc_scan_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DATA_W      = ADC_DATA_W,
    parameter int ADDR_W      = ADC_ADDR_W,
    parameter int HIGH        = 3000,
    parameter int LOW         = 1000,
    parameter int PAUSE_CYC   = 30,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic                     err_clr,
    adc_scan_hyst_if.master          adc,
    output logic [N_CH*DATA_W-1:0]   ch_data,
    output logic [N_CH-1:0]          ch_flag,
    output logic                     sample_valid,
    output logic [ADDR_W-1:0]        sample_ch,
    output logic                     scan_done,
    output logic                     timeout_err
);

    localparam int CNT_MAX = (TIMEOUT_CYC > PAUSE_CYC) ? TIMEOUT_CYC : PAUSE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYC - 1);

    if (N_CH < 1 || N_CH > 8 || N_CH > 2**ADDR_W) begin : g_bad_nch
        $error("adc_scan_hyst: N_CH must be 1..8 and fit in ADDR_W");
    end
    if (LOW >= HIGH) begin : g_bad_thresh
        $error("adc_scan_hyst: LOW must be below HIGH");
    end
    if (PAUSE_CYC < 1) begin : g_bad_pause
        $error("adc_scan_hyst: PAUSE_CYC must be at least 1");
    end

    scan_state_t       state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [N_CH-1:0]   scan_mask;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sample_reg;
    logic [ADDR_W-1:0] sel_ch;
    logic [ADDR_W-1:0] last_ch;
    int                best_d;
    logic              go;
    logic              select;
    logic              timed_out;
    logic              upd;

    assign go        = en && (|ch_mask);
    assign select    = (state_next == REQ) && (state != REQ);
    assign timed_out = (state == REQ) && !adc.adc_ready && (cnt == TO_LAST);
    assign upd       = (state == ACK) && !adc.adc_ready;

    // Pick the enabled channel at the smallest forward distance after the pointer.
    always_comb begin
        sel_ch = '0;
        best_d = N_CH;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_mask[i] && (((i + N_CH - 1 - int'(ptr)) % N_CH) < best_d)) begin
                best_d = (i + N_CH - 1 - int'(ptr)) % N_CH;
                sel_ch = ADDR_W'(i);
            end
        end
    end

    // Scan completion is judged against the mask captured when this channel was selected.
    always_comb begin
        last_ch = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (scan_mask[i]) begin
                last_ch = ADDR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (go) state_next = REQ;
            end
            REQ: begin
                if (adc.adc_ready)   state_next = ACK;
                else if (timed_out)  state_next = PAUSE;
            end
            ACK: begin
                if (!adc.adc_ready)  state_next = PAUSE;
            end
            PAUSE: begin
                if (cnt == PAUSE_LAST) state_next = go ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        adc.ctl_valid = (state == REQ);
        adc.address   = (state == REQ) ? ptr : '0;
        adc.adc_ack   = (state == ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= ADDR_W'(N_CH - 1);
            scan_mask    <= '0;
            cnt          <= '0;
            sample_reg   <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            scan_done    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (select) begin
                ptr       <= sel_ch;
                scan_mask <= ch_mask;
            end
            if (state_next != state) begin
                cnt <= '0;
            end else if (state == REQ || state == PAUSE) begin
                cnt <= cnt + 1'b1;
            end
            if (state == REQ && adc.adc_ready) begin
                sample_reg <= adc.adc_data;
            end
            sample_valid <= upd;
            scan_done    <= upd && (ptr == last_ch);
            if (upd) begin
                sample_ch <= ptr;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_cell
        adc_hyst_cell #(
            .DATA_W (DATA_W),
            .HIGH   (HIGH),
            .LOW    (LOW)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .upd    (upd && (ptr == ADDR_W'(i))),
            .sample (sample_reg),
            .value  (ch_data[i*DATA_W +: DATA_W]),
            .flag   (ch_flag[i])
        );
    end

endmodule
